// File: rtl/jts16_sndcmd.sv
// jts16_sndcmd: main-to-sound CPU command mailbox with NMI handshake.
// A falling edge on main_irqn queues main_latch. The sound CPU gets one NMI
// low period per queued command and pops the head at the end of each snd_cs
// read pulse. Between commands the NMI is held high for GAP cycles.
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   main_latch  - command byte from the main CPU
//   main_irqn   - command strobe, falling edge pushes
//   snd_cs      - sound CPU read strobe, falling edge pops
//   snd_dout    - FIFO head, or the last popped byte when empty (0xFF after reset)
//   snd_nmin    - active-low NMI to the sound CPU
//   snd_ack     - high when no command is pending
//   ovf         - sticky overflow flag
//   st_dout     - debug status {ovf, nmi_state[1:0], 2'b0, count[2:0]}
//
// Build option: define JTS16_SNDCMD_FIFO_EN for a 4-entry command FIFO.
// Otherwise the mailbox holds one byte and a push while full overwrites it.
module jts16_sndcmd #(
  parameter int unsigned GAP = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] main_latch,
  input  logic       main_irqn,
  input  logic       snd_cs,
  output logic [7:0] snd_dout,
  output logic       snd_nmin,
  output logic       snd_ack,
  output logic       ovf,
  output logic [7:0] st_dout
);

`ifdef JTS16_SNDCMD_FIFO_EN
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned PTR_STEP  = 1;
  localparam bit          OVERWRITE = 1'b0;
`else
  localparam int unsigned DEPTH     = 1;
  localparam int unsigned PTR_STEP  = 0;
  localparam bit          OVERWRITE = 1'b1;
`endif
  localparam int unsigned PW = 2;
  localparam int unsigned CW = 3;
  localparam int unsigned GW = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } nmi_state_e;

  logic             irqn_q, cs_q;
  logic [7:0]       mem_q [4];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       last_q, last_d;
  logic [7:0]       dout_q, dout_d;
  logic             nmin_q, nmin_d;
  logic             ack_q, ack_d;
  nmi_state_e       state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic             push, pop, full, grow, we, has_cmd;
  logic [7:0]       head_d;

  assign push = irqn_q & ~main_irqn;
  assign pop  = cs_q & ~snd_cs & (count_q != '0);
  assign full = (count_q == CW'(DEPTH));

  // FIFO pointer/count bookkeeping and next value of the presented byte
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    last_d   = last_q;
    grow     = push & (~full | pop);
    we       = grow | (push & full & ~pop & OVERWRITE);
    if (push && full && !pop) ovf_d = 1'b1;
    if (grow) wr_ptr_d = wr_ptr_q + PW'(PTR_STEP);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(PTR_STEP);
      last_d   = mem_q[rd_ptr_q];
    end
    count_d = count_q + CW'(grow) - CW'(pop);
    // head after this cycle's write lands (covers push into empty/overwrite)
    head_d  = (we && (wr_ptr_q == rd_ptr_d)) ? main_latch : mem_q[rd_ptr_d];
    dout_d  = (count_d != '0) ? head_d : last_d;
  end

  // A command must survive this cycle's pop before an NMI is raised for it
  assign has_cmd = (count_q != '0) && (count_d != '0);

  // NMI sequencer: next state and registered outputs
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (has_cmd) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (pop) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          state_d = has_cmd ? ST_ASSERT : ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
    endcase
    nmin_d = (state_d != ST_ASSERT);
    ack_d  = (count_q == '0);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irqn_q   <= 1'b1;
      cs_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      last_q   <= 8'hFF;
      dout_q   <= 8'hFF;
      nmin_q   <= 1'b1;
      ack_q    <= 1'b1;
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      irqn_q   <= main_irqn;
      cs_q     <= snd_cs;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
      dout_q   <= dout_d;
      nmin_q   <= nmin_d;
      ack_q    <= ack_d;
      state_q  <= state_d;
      gap_q    <= gap_d;
      if (we) mem_q[wr_ptr_q] <= main_latch;
    end
  end

  assign snd_dout = dout_q;
  assign snd_nmin = nmin_q;
  assign snd_ack  = ack_q;
  assign ovf      = ovf_q;
  assign st_dout  = {ovf_q, state_q, 2'b00, count_q};

endmodule
